// File: rtl/list_pkg.sv
// Shared list-path definitions: default widths, lane derivation and beat record.
package list_pkg;
    localparam int DW_DEF  = 32;
    localparam int DBW_DEF = 256;
    localparam int FS_DEF  = DBW_DEF / DW_DEF;
    localparam int LW_DEF  = (FS_DEF > 1) ? $clog2(FS_DEF) : 1;

    // Lanes per beat for a given bus/word width pair.
    function automatic int lanes_of(input int dbw, input int dw);
        return dbw / dw;
    endfunction

    // Lane index width for a given lane count.
    function automatic int lane_w(input int fs);
        return (fs > 1) ? $clog2(fs) : 1;
    endfunction

    // One AXI4-Stream beat as exchanged with list_cache.
    typedef struct packed {
        logic [DBW_DEF-1:0]   data;
        logic [DBW_DEF/8-1:0] keep;
        logic                 last;
    } beat_t;
endpackage

// File: rtl/list_writer_beat_fifo.sv
// Beat FIFO whose tail entry is filled lane by lane before being sealed.
module beat_fifo
    import list_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int DBW = DBW_DEF,
    parameter int BS  = 2,
    parameter int LW  = LW_DEF,
    parameter int CW  = $clog2(BS + 1)
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             wr_en,
    input  logic [LW-1:0]    wr_lane,
    input  logic [DW-1:0]    wr_word,
    input  logic [DBW/8-1:0] wr_keep,
    input  logic             wr_last,
    input  logic             seal,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [DBW-1:0]   head_data,
    output logic [DBW/8-1:0] head_keep,
    output logic             head_last
);
    localparam int PW = (BS > 1) ? $clog2(BS) : 1;

    logic [BS-1:0][DBW-1:0]   mem_data;
    logic [BS-1:0][DBW/8-1:0] mem_keep;
    logic [BS-1:0]            mem_last;
    logic [PW-1:0]            wr_ptr, rd_ptr;

    // Fill entry, pointers and occupancy; pointers wrap by width alone.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            mem_data <= '0;
            mem_keep <= '0;
            mem_last <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (wr_en) begin
                // First lane of a beat wipes stale lanes so unused lanes read 0.
                if (wr_lane == '0)
                    mem_data[wr_ptr] <= {{(DBW-DW){1'b0}}, wr_word};
                else
                    mem_data[wr_ptr][int'(wr_lane)*DW +: DW] <= wr_word;
                mem_keep[wr_ptr] <= wr_keep;
                mem_last[wr_ptr] <= wr_last;
            end
            if (seal) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (seal && !pop)      count <= count + 1'b1;
            else if (!seal && pop) count <= count - 1'b1;
        end
    end

    assign head_data = mem_data[rd_ptr];
    assign head_keep = mem_keep[rd_ptr];
    assign head_last = mem_last[rd_ptr];
endmodule

// File: rtl/list_writer.sv
// Packs HoP words into AXI4-Stream beats, sealing on a full beat or list end.
module list_writer
    import list_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int DBW = DBW_DEF,
    parameter int BS  = 2
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic [DW-1:0]    IN,
    input  logic             I_VALID,
    input  logic             I_LAST,
    output logic             O_READY,
    output logic [DBW-1:0]   TDATA,
    output logic [DBW/8-1:0] TKEEP,
    output logic             TLAST,
    output logic             TVALID,
    input  logic             TREADY
);
    localparam int FS = lanes_of(DBW, DW);
    localparam int LW = lane_w(FS);
    localparam int CW = $clog2(BS + 1);
    localparam int BPW = DW / 8;

    logic [LW-1:0]    lane;
    logic [CW-1:0]    count, cnt_nxt;
    logic [DBW/8-1:0] keep;
    logic             acc, seal, pop;

    assign acc    = I_VALID & O_READY;
    assign seal   = acc & (I_LAST | (lane == LW'(FS - 1)));
    assign pop    = TVALID & TREADY;
    assign TVALID = (count != '0);

    // Keep covers every lane up to and including the one being written.
    always_comb begin
        keep = '0;
        for (int k = 0; k < FS; k++)
            if (k <= int'(lane)) keep[k*BPW +: BPW] = '1;
    end

    // Occupancy after this edge decides whether the next word can be taken.
    always_comb begin
        cnt_nxt = count;
        if (seal && !pop)      cnt_nxt = count + 1'b1;
        else if (!seal && pop) cnt_nxt = count - 1'b1;
    end

    // Lane counter and registered ready.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            lane    <= '0;
            O_READY <= 1'b0;
        end else begin
            if (seal)     lane <= '0;
            else if (acc) lane <= lane + 1'b1;
            O_READY <= (int'(cnt_nxt) < BS);
        end
    end

    beat_fifo #(.DW(DW), .DBW(DBW), .BS(BS), .LW(LW), .CW(CW)) u_fifo (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .wr_en     (acc),
        .wr_lane   (lane),
        .wr_word   (IN),
        .wr_keep   (keep),
        .wr_last   (I_LAST),
        .seal      (seal),
        .pop       (pop),
        .count     (count),
        .head_data (TDATA),
        .head_keep (TKEEP),
        .head_last (TLAST)
    );
endmodule

// File: tb/tb_list_writer.sv
// Scoreboard bench for list_writer: reference packer feeds expected beats.
module tb_list_writer;
    localparam int DW = 32, DBW = 256, BS = 2, FS = DBW / DW;

    logic             ACLK, ARESETn;
    logic [DW-1:0]    IN;
    logic             I_VALID, I_LAST, O_READY;
    logic [DBW-1:0]   TDATA;
    logic [DBW/8-1:0] TKEEP;
    logic             TLAST, TVALID, TREADY;

    list_writer #(.DW(DW), .DBW(DBW), .BS(BS)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .IN(IN), .I_VALID(I_VALID),
        .I_LAST(I_LAST), .O_READY(O_READY), .TDATA(TDATA), .TKEEP(TKEEP),
        .TLAST(TLAST), .TVALID(TVALID), .TREADY(TREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [DBW-1:0]   d;
        logic [DBW/8-1:0] k;
        logic             l;
    } exp_t;

    exp_t           q[$];
    int             checks = 0, fails = 0;
    int             m_cnt = 0, m_lane = 0, cyc = 0, words_acc = 0, last_acc_cyc = 0;
    logic           m_rdy = 1'b0, acc_flag = 1'b0;
    logic [DBW-1:0] m_data = '0;

    task automatic chk(input string tag, input logic [DBW-1:0] obs, input logic [DBW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference model: packs accepted words and tracks beat occupancy.
    always @(posedge ACLK or negedge ARESETn) begin
        logic acc, pop, seal;
        exp_t e;
        if (!ARESETn) begin
            m_cnt = 0; m_rdy = 1'b0; m_lane = 0; m_data = '0; acc_flag = 1'b0;
            q.delete();
        end else begin
            cyc++;
            acc  = I_VALID && m_rdy;
            pop  = (m_cnt > 0) && TREADY;
            seal = 1'b0;
            acc_flag = acc;
            if (acc) begin
                m_data[m_lane*DW +: DW] = IN;
                words_acc++;
                last_acc_cyc = cyc;
                if (I_LAST || m_lane == FS - 1) begin
                    e.d = m_data;
                    e.k = '0;
                    for (int k = 0; k <= m_lane; k++) e.k[k*4 +: 4] = 4'hF;
                    e.l = I_LAST;
                    q.push_back(e);
                    seal = 1'b1; m_lane = 0; m_data = '0;
                end else m_lane++;
            end
            if (pop) void'(q.pop_front());
            m_cnt = m_cnt + int'(seal) - int'(pop);
            m_rdy = (m_cnt < BS);
        end
    end

    // Output monitor: handshake flags and head beat every cycle.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            chk("o_ready", DBW'(O_READY), DBW'(m_rdy));
            chk("tvalid", DBW'(TVALID), DBW'(m_cnt > 0));
            if (m_cnt > 0) begin
                if (q.size() == 0) chk("sb_empty", 1, 0);
                else begin
                    chk("tdata", TDATA, q[0].d);
                    chk("tkeep", DBW'(TKEEP), DBW'(q[0].k));
                    chk("tlast", DBW'(TLAST), DBW'(q[0].l));
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] w, input logic l);
        logic done;
        done = 1'b0;
        IN = w; I_LAST = l; I_VALID = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            @(posedge ACLK); #1;
            if (acc_flag) done = 1'b1;
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        I_VALID = 1'b0; TREADY = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge ACLK); #1;
            if (q.size() == 0 && m_cnt == 0) done = 1'b1;
        end
        chk("drain", DBW'(q.size()), 0);
    endtask

    initial begin
        int w0, c0;
        logic rdone;
        ARESETn = 1'b0; IN = '0; I_VALID = 1'b0; I_LAST = 1'b0; TREADY = 1'b0;
        #12;
        chk("rst_tvalid", DBW'(TVALID), 0);
        chk("rst_oready", DBW'(O_READY), 0);
        chk("rst_tkeep", DBW'(TKEEP), 0);
        chk("rst_tdata", TDATA, 0);
        chk("rst_tlast", DBW'(TLAST), 0);
        @(posedge ACLK); #2 ARESETn = 1'b1;
        @(posedge ACLK); #1;
        chk("rdy_after_rst", DBW'(O_READY), 1);

        // Full beat 1..8.
        TREADY = 1'b1;
        for (int k = 1; k <= 8; k++) send(DW'(k), 1'b0);
        I_VALID = 1'b0;
        chk("lat_tvalid", DBW'(TVALID), 1);
        chk("full_keep", DBW'(TKEEP), DBW'(32'hFFFF_FFFF));
        drain();

        // Short list A,B,C.
        send(32'hA, 1'b0); send(32'hB, 1'b0); send(32'hC, 1'b1);
        I_VALID = 1'b0;
        chk("abc_keep", DBW'(TKEEP), DBW'(32'h0000_0FFF));
        chk("abc_last", DBW'(TLAST), 1);
        drain();

        // Single-word list.
        send(32'h55, 1'b1);
        I_VALID = 1'b0;
        chk("one_keep", DBW'(TKEEP), DBW'(32'h0000_000F));
        drain();

        // Backpressure: 24 words offered, only 16 fit.
        TREADY = 1'b0;
        w0 = words_acc;
        fork
            begin
                for (int k = 0; k < 24; k++) send(DW'(32'h200 + k), 1'b0);
                I_VALID = 1'b0;
            end
            begin
                repeat (40) @(posedge ACLK);
                #1;
                chk("stall_words", DBW'(words_acc - w0), 16);
                chk("stall_rdy", DBW'(O_READY), 0);
                TREADY = 1'b1;
            end
        join
        drain();

        // Throughput: 64 words in 64 cycles.
        TREADY = 1'b1;
        w0 = words_acc; c0 = cyc;
        for (int k = 0; k < 64; k++) send(DW'(32'h1000 + k), 1'b0);
        I_VALID = 1'b0;
        chk("tput_words", DBW'(words_acc - w0), 64);
        chk("tput_cycles", DBW'(last_acc_cyc - c0), 64);
        drain();

        // Reset with a queued beat and a partial beat.
        TREADY = 1'b0;
        for (int k = 0; k < 13; k++) send(DW'(32'h300 + k), 1'b0);
        I_VALID = 1'b0;
        @(posedge ACLK); #1 ARESETn = 1'b0;
        #1;
        chk("mid_rst_tvalid", DBW'(TVALID), 0);
        chk("mid_rst_oready", DBW'(O_READY), 0);
        @(posedge ACLK); #2 ARESETn = 1'b1;
        chk("rel_rdy_low", DBW'(O_READY), 0);
        @(posedge ACLK); #1;
        chk("rel_rdy_high", DBW'(O_READY), 1);
        TREADY = 1'b1;
        repeat (4) @(posedge ACLK);
        #1 chk("rel_no_beat", DBW'(TVALID), 0);
        for (int k = 0; k < 8; k++) send(DW'(32'h400 + k), 1'b0);
        I_VALID = 1'b0;
        drain();

        // Random words, random list ends, random backpressure.
        rdone = 1'b0;
        fork
            begin
                for (int k = 0; k < 32; k++)
                    send(DW'($urandom), (k == 31) || ($urandom_range(0, 5) == 0));
                I_VALID = 1'b0;
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(negedge ACLK);
                    TREADY = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/list_writer.md
LIST_WRITER -- requirements
Module: list_writer

Interface
REQ-001 SHALL have parameter DW, default 32, HoP word width in bits.
REQ-002 SHALL have parameter DBW, default 256, AXI4-Stream data bus width in bits; DBW multiple of DW, DW multiple of 8.
REQ-003 SHALL have parameter BS, default 2, beat buffer depth in beats; power of two.
REQ-004 ACLK  input  1  single clock; all logic on rising edge.
REQ-005 ARESETn  input  1  reset, asynchronous assert, active-low.
REQ-006 IN  input  DW  word from HoP module.
REQ-007 I_VALID  input  1  IN valid.
REQ-008 I_LAST  input  1  IN is final word of current list.
REQ-009 O_READY  output  1  block accepts IN this cycle.
REQ-010 TDATA  output  DBW  packed beat; lane k in bits [k*DW +: DW].
REQ-011 TKEEP  output  DBW/8  byte-valid mask of TDATA.
REQ-012 TLAST  output  1  beat ends a list.
REQ-013 TVALID  output  1  beat valid.
REQ-014 TREADY  input  1  downstream accepts beat.

Function
REQ-015 Word accepted SHALL be I_VALID & O_READY at rising edge; FS = DBW/DW lanes per beat.
REQ-016 Lane counter SHALL start at 0; accepted word written to lane counter position of fill entry, counter incremented.
REQ-017 Beat SHALL be sealed when word accepted into lane FS-1 or with I_LAST=1; lane counter returns to 0 same edge.
REQ-018 Sealed beat SHALL carry TKEEP ones for bytes of lanes 0..n (n = lane of sealing word), zeros above; unwritten lanes of TDATA SHALL read 0.
REQ-019 Sealed beat SHALL carry TLAST = I_LAST of sealing word.
REQ-020 Sealed beats SHALL enter FIFO of BS entries; beat count range 0..BS.
REQ-021 O_READY SHALL be registered; high iff beat count after current edge < BS.
REQ-022 TVALID SHALL be high iff beat count > 0; TDATA/TKEEP/TLAST driven from FIFO head.
REQ-023 Beat popped when TVALID & TREADY; TDATA/TKEEP/TLAST/TVALID SHALL be stable while TVALID & ~TREADY.
REQ-024 Seal and pop same edge SHALL leave count unchanged; both pointers advance.
REQ-025 Latency: sealing word accepted at edge N into empty FIFO -> TVALID high after edge N.
REQ-026 Throughput: with TREADY held high, SHALL accept one word per cycle indefinitely.
REQ-027 Full FIFO (count=BS): O_READY low; no word accepted; lane counter and partial data hold.
REQ-028 Pointer and lane counters SHALL wrap modulo BS and FS without extra logic.
REQ-029 I_LAST on first word of beat SHALL produce single-lane beat, TKEEP = DW/8 low bits set, TLAST=1.

Reset
REQ-030 ARESETn low SHALL asynchronously clear: TVALID=0, O_READY=0, TLAST=0, TKEEP=0, TDATA=0, count=0, pointers=0, lane counter=0.
REQ-031 O_READY SHALL rise on first rising edge after ARESETn deasserts.
REQ-032 Reset mid-list SHALL discard partial beat and all queued beats; no beat emitted after release until new words arrive.

Structure
REQ-033 Package list_pkg SHALL hold DW, DBW defaults, FS derivation, lane index width, and the beat struct (data, keep, last) shared with list_cache.
REQ-034 FIFO SHALL be sub-module beat_fifo (BS entries, count, push/pop, in-place fill of tail entry); list_writer holds lane counter, keep generation, O_READY register.

Verification
REQ-035 8 words 1..8, I_VALID high, TREADY high -> one beat, lane k = k+1, TKEEP=all ones, TLAST=0, TVALID one cycle after 8th word.
REQ-036 3 words 0xA,0xB,0xC with I_LAST on 0xC -> beat lanes 0..2 = A,B,C, lanes 3..7 zero, TKEEP=0x00000FFF, TLAST=1.
REQ-037 TREADY low, 24 words offered -> O_READY drops after 16 words; TREADY high -> 2 beats out in order, remaining 8 words accepted, third beat correct.
REQ-038 Word 9 accepted same cycle beat 1 popped, TREADY high continuously -> count steady at 1, no O_READY bubble, 64 words in 64 cycles.
REQ-039 ARESETn pulsed low after 5 words of list -> TVALID=0 immediately, O_READY high one edge after release, next 8 words form clean beat lanes 0..7.
REQ-040 Loopback list_writer -> list_cache, 32 random words -> list_cache OUT sequence equals input sequence.
